// File: rtl/lowampa_capture_pkg.sv
// Shared state encoding, header field positions and parameter check for the
// low-amplitude trigger snapshot controller.
package lowampa_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_READOUT
    } cap_state_e;

    // Header beat layout: {64'h0, trig_count[15:0], 16'h0, timestamp[31:0]}
    localparam int HDR_TS_LSB  = 0;
    localparam int HDR_TS_W    = 32;
    localparam int HDR_CNT_LSB = 48;
    localparam int HDR_CNT_W   = 16;

    function automatic bit pre_words_ok(input int pre_words, input int depth_log2);
        return (pre_words >= 1) && (pre_words < (1 << depth_log2));
    endfunction

endpackage

// File: rtl/capture_ring_bram.sv
// Simple dual-port ring buffer: one write port, one registered read port
// with a single cycle of read latency.
module capture_ring_bram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; every word read
    // back is written earlier in the same capture.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/lowampa_capture_ctrl.sv
// Trigger-driven snapshot controller: ring capture, pre/post trigger window,
// AXI4-Stream readout. LOWAMPA_CAPTURE_TIMESTAMP_EN adds a timestamp header beat.
module lowampa_capture_ctrl
    import lowampa_capture_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_WORDS  = 256
) (
    input  logic              aclk,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              trigger_i,
    input  logic              arm_i,
    output logic              armed_o,
    output logic              done_o,
    output logic [15:0]       trig_count_o,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam int AW         = DEPTH_LOG2;
    localparam int DEPTH      = 1 << AW;
    localparam int POST_WORDS = DEPTH - PRE_WORDS;
    localparam int IW         = AW + 1;

    if (!pre_words_ok(PRE_WORDS, DEPTH_LOG2)) begin : g_bad_pre_words
        $error("PRE_WORDS must lie in [1, 2**DEPTH_LOG2)");
    end

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [IW-1:0]     iss_q, iss_d;
    logic [15:0]       trig_cnt_q, trig_cnt_d;
    logic              done_q, done_d;
    logic              rd_vld_q, rd_last_q, rd_hdr_q;
    logic              rd_issue, issue_hdr, wr_en, rd_en, pop, slot;
    logic [2:0]        occ;
    logic [1:0]        fcnt_q, fcnt_d;
    beat_t             ent_q [2];
    beat_t             ent_d [2];
    beat_t             push_beat;
    logic [DATA_W-1:0] rd_data, hdr_word;

`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    logic [31:0] ts_q, ts_lat_q;
    logic        trig_beat;

    assign trig_beat = (state_q == ST_ARMED) && s_tvalid && trigger_i;

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (trig_beat) begin
                ts_lat_q <= ts_q;
            end
        end
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_TS_LSB +: HDR_TS_W]   = ts_lat_q;
        hdr_word[HDR_CNT_LSB +: HDR_CNT_W] = trig_cnt_q;
    end
`else
    localparam bit TS_EN = 1'b0;
    assign hdr_word = '0;
`endif

    localparam int            N_BEATS   = DEPTH + (TS_EN ? 1 : 0);
    localparam logic [AW-1:0] PRE_W     = AW'(PRE_WORDS);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_WORDS - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_WORDS - 2);
    localparam logic [IW-1:0] N_ISS     = IW'(N_BEATS);
    localparam logic [IW-1:0] LAST_ISS  = IW'(N_BEATS - 1);

    assign m_tvalid     = (fcnt_q != 2'd0);
    assign m_tdata      = ent_q[0].data;
    assign m_tlast      = ent_q[0].last;
    assign armed_o      = (state_q == ST_ARMED);
    assign done_o       = done_q;
    assign trig_count_o = trig_cnt_q;

    assign pop       = m_tvalid && m_tready;
    assign occ       = {1'b0, fcnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign issue_hdr = TS_EN && (iss_q == '0);
    assign rd_en     = rd_issue && !issue_hdr;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        iss_d      = iss_q;
        trig_cnt_d = trig_cnt_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        rd_issue   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_FILL: begin
                if (s_tvalid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (s_tvalid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (trigger_i) begin
                        // Readout pointer starts at the oldest pre-trigger word.
                        rd_addr_d = wr_ptr_q - PRE_W;
                        iss_d     = '0;
                        cnt_d     = '0;
                        if (trig_cnt_q != 16'hFFFF) begin
                            trig_cnt_d = trig_cnt_q + 16'd1;
                        end
                        state_d = (POST_WORDS == 1) ? ST_READOUT : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (s_tvalid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == POST_LAST) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                // Read-ahead only while the in-flight word is sure to find a skid slot.
                if ((iss_q != N_ISS) && (occ < 3'd2)) begin
                    rd_issue = 1'b1;
                    iss_d    = iss_q + IW'(1);
                    if (!issue_hdr) begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
                if (pop && m_tlast) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ent_d     = ent_q;
        push_beat = '{last: rd_last_q, data: (rd_hdr_q ? hdr_word : rd_data)};
        slot      = (fcnt_q == 2'd2) || ((fcnt_q == 2'd1) && !pop);
        if (pop) begin
            ent_d[0] = ent_q[1];
        end
        if (rd_vld_q) begin
            ent_d[slot] = push_beat;
        end
        fcnt_d = fcnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            iss_q      <= '0;
            trig_cnt_q <= '0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_hdr_q   <= 1'b0;
            fcnt_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            iss_q      <= iss_d;
            trig_cnt_q <= trig_cnt_d;
            done_q     <= done_d;
            rd_vld_q   <= rd_issue;
            rd_last_q  <= rd_issue && (iss_q == LAST_ISS);
            rd_hdr_q   <= rd_issue && issue_hdr;
            fcnt_q     <= fcnt_d;
            ent_q      <= ent_d;
        end
    end

    capture_ring_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ring (
        .clk       (aclk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (s_tdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// Self-checking bench for lowampa_capture_ctrl (DEPTH_LOG2=4, PRE_WORDS=4),
// default build without the timestamp header.
module tb_lowampa_capture_ctrl;

    localparam int DW    = 128;
    localparam int DL    = 4;
    localparam int PW    = 4;
    localparam int DEPTH = 1 << DL;

    logic          aclk = 1'b0;
    logic          reset_i, s_tvalid, trigger_i, arm_i, m_tready;
    logic [DW-1:0] s_tdata;
    logic          armed_o, done_o, m_tvalid, m_tlast;
    logic [15:0]   trig_count_o;
    logic [DW-1:0] m_tdata;

    always #5 aclk = ~aclk;

    lowampa_capture_ctrl #(
        .DATA_W     (DW),
        .DEPTH_LOG2 (DL),
        .PRE_WORDS  (PW)
    ) dut (
        .aclk         (aclk),
        .reset_i      (reset_i),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .trigger_i    (trigger_i),
        .arm_i        (arm_i),
        .armed_o      (armed_o),
        .done_o       (done_o),
        .trig_count_o (trig_count_o),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast)
    );

    // One capture scenario; exp_first is the window's first index in the
    // post-arm valid-beat log (-1: derived from the model only).
    typedef struct {
        string tag;
        int    trig_at;
        bit    hold;
        int    vmode;
        int    rpct;
        int    exp_first;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned k = 0;
    int          exp_trigs = 0;

    function automatic logic [DW-1:0] word(input int unsigned v);
        return {v, ~v, v ^ 32'hDEAD_BEEF, v * 32'd7};
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_capture(input vec_t v, input int rst_beat);
        logic [DW-1:0] log_d[$];
        bit            log_t[$];
        int            log_it[$];
        logic [DW-1:0] got_d[$];
        bit            got_l[$];
        logic [DW:0]   stall_v;
        logic [DW-1:0] exp_d;
        int done_cnt = 0, done_it = -1, last_it = -1, first_it = -1;
        int rise_it = -1, fall_it = -1, ti = -1, base;
        bit stalled = 1'b0, trig_sent = 1'b0, vld, trg;

        arm_i     = 1'b1;
        s_tvalid  = 1'b1;
        s_tdata   = word(k);
        k++;
        trigger_i = v.hold;
        m_tready  = 1'b0;
        tick();
        arm_i = 1'b0;

        for (int it = 1; it < 600; it++) begin
            if (rst_beat >= 0 && got_d.size() == rst_beat && m_tvalid) begin
                reset_i   = 1'b1;
                s_tvalid  = 1'b0;
                trigger_i = 1'b0;
                m_tready  = 1'b0;
                tick();
                reset_i = 1'b0;
                check({v.tag, " rst m_tvalid"}, 160'(m_tvalid), 160'(0));
                check({v.tag, " rst armed_o"}, 160'(armed_o), 160'(0));
                check({v.tag, " rst trig_count"}, 160'(trig_count_o), 160'(0));
                check({v.tag, " rst m_tlast"}, 160'(m_tlast), 160'(0));
                check({v.tag, " rst done_o"}, 160'(done_o), 160'(0));
                exp_trigs = 0;
                return;
            end
            if (stalled) begin
                check($sformatf("%s stall hold it%0d", v.tag, it),
                      160'({m_tvalid, m_tlast, m_tdata}), 160'({1'b1, stall_v}));
            end
            if (m_tvalid && first_it < 0) first_it = it;
            if (armed_o && rise_it < 0) rise_it = it;
            if (!armed_o && rise_it >= 0 && fall_it < 0) fall_it = it;
            if (done_o) begin
                done_cnt++;
                done_it = it;
            end

            case (v.vmode)
                0:       vld = 1'b1;
                1:       vld = trig_sent ? (it % 2 == 0) : 1'b1;
                default: vld = ($urandom_range(99) < 70);
            endcase
            trg = v.hold ? 1'b1 : (vld && log_d.size() == v.trig_at);
            if (vld && trg) trig_sent = 1'b1;
            s_tvalid  = vld;
            trigger_i = trg;
            s_tdata   = vld ? word(k) : ~word(k);
            if (vld) begin
                log_d.push_back(word(k));
                log_t.push_back(trg);
                log_it.push_back(it);
                k++;
            end
            m_tready = ($urandom_range(99) < v.rpct);
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_l.push_back(m_tlast);
                if (m_tlast) last_it = it;
            end
            stalled = m_tvalid && !m_tready;
            stall_v = {m_tlast, m_tdata};
            tick();
            if (done_cnt > 0 && it >= done_it + 2) break;
        end
        s_tvalid  = 1'b0;
        trigger_i = 1'b0;
        m_tready  = 1'b0;

        check({v.tag, " done seen in budget"}, 160'(done_cnt > 0), 160'(1));
        // Model: the trigger word is the first flagged beat after PRE_WORDS fill beats.
        for (int i = PW; i < log_t.size(); i++) begin
            if (log_t[i]) begin
                ti = i;
                break;
            end
        end
        check({v.tag, " trigger found"}, 160'(ti >= 0), 160'(1));
        if (ti >= 0) begin
            base = ti - PW;
            if (v.exp_first >= 0) check({v.tag, " first index"}, 160'(base), 160'(v.exp_first));
            check({v.tag, " beat count"}, 160'(got_d.size()), 160'(DEPTH));
            for (int i = 0; i < got_d.size() && i < DEPTH; i++) begin
                exp_d = (base + i < log_d.size()) ? log_d[base + i] : '0;
                check($sformatf("%s data[%0d]", v.tag, i), 160'(got_d[i]), 160'(exp_d));
                check($sformatf("%s tlast[%0d]", v.tag, i), 160'(got_l[i]), 160'(i == DEPTH - 1));
            end
            check({v.tag, " armed rise"}, 160'(rise_it), 160'(log_it[PW - 1] + 1));
            check({v.tag, " armed fall"}, 160'(fall_it), 160'(log_it[ti] + 1));
            if (v.vmode == 0) begin
                check({v.tag, " trig-to-first latency"}, 160'(first_it - log_it[ti]),
                      160'(DEPTH - PW + 2));
            end
            exp_trigs = (exp_trigs < 65535) ? exp_trigs + 1 : 65535;
        end
        check({v.tag, " trig_count"}, 160'(trig_count_o), 160'(exp_trigs));
        check({v.tag, " done pulses"}, 160'(done_cnt), 160'(1));
        check({v.tag, " done after tlast"}, 160'(done_it), 160'(last_it + 1));
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;

        reset_i   = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        trigger_i = 1'b0;
        arm_i     = 1'b0;
        m_tready  = 1'b0;
        tick();
        tick();
        check("reset armed_o", 160'(armed_o), 160'(0));
        check("reset done_o", 160'(done_o), 160'(0));
        check("reset trig_count", 160'(trig_count_o), 160'(0));
        check("reset m_tvalid", 160'(m_tvalid), 160'(0));
        check("reset m_tlast", 160'(m_tlast), 160'(0));
        check("reset m_tdata", 160'(m_tdata), 160'(0));
        reset_i = 1'b0;
        tick();

        vecs.push_back('{"basic",       20, 1'b0, 0, 100, 16});
        vecs.push_back('{"wrap",        18, 1'b0, 0, 100, 14});
        vecs.push_back('{"early",       -1, 1'b1, 0, 100,  0});
        vecs.push_back('{"backpress",   20, 1'b0, 0,  30, 16});
        vecs.push_back('{"gaps",        10, 1'b0, 1, 100,  6});
        vecs.push_back('{"trig_at_pre",  4, 1'b0, 0, 100,  0});
        for (int i = 0; i < vecs.size(); i++) begin
            run_capture(vecs[i], -1);
        end

        for (int r = 0; r < 8; r++) begin
            v.tag       = $sformatf("rand%0d", r);
            v.trig_at   = $urandom_range(40, PW);
            v.hold      = ($urandom_range(7) == 0);
            v.vmode     = $urandom_range(2);
            v.rpct      = $urandom_range(100, 30);
            v.exp_first = -1;
            run_capture(v, -1);
        end

        // Reset in the middle of readout, then a clean capture afterwards.
        run_capture('{"midrst", 20, 1'b0, 0, 100, 16}, 7);
        tick();
        run_capture('{"after_rst", 20, 1'b0, 0, 100, 16}, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
